pls_gen_div: RTL and testbench

PLS_GEN_DIV -- requirements
Module: pls_gen_div

---
 rtl/pls_pkg.sv | 18 +
 rtl/pls_tally_100.sv | 52 +++++
 rtl/pls_gen_div.sv | 138 +++++++++++++
 tb/tb_pls_gen_div.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/pls_pkg.sv
// Shared definitions for the pulse generator / divider.
//   CNT_W_DEF    : default width of the half-period setting and phase timer
//   MIN_HALF_DEF : default minimum clocks per output level
//   PCNT_MOD     : modulus of the completed-pulse counter
//   state_e      : pulse generator FSM state encoding
package pls_pkg;

  localparam int CNT_W_DEF    = 16;
  localparam int MIN_HALF_DEF = 2;
  localparam int PCNT_MOD     = 100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

endpackage

// File: rtl/pls_tally_100.sv
// Modulo-100 completed-pulse counter with a one-clock rollover strobe.
//   clk  : system clock
//   rst  : synchronous active-low reset
//   inc  : count one completed pulse this clock
//   clr  : synchronous clear, priority over inc
//   pcnt : count, 0..99
//   wrap : one-clock strobe on the 99 -> 0 step
module pls_tally_100
  import pls_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  output logic [6:0] pcnt,
  output logic       wrap
);

  localparam logic [6:0] PCNT_LAST = 7'(PCNT_MOD - 1);

  logic [6:0] pcnt_q, pcnt_d;
  logic       wrap_q, wrap_d;

  always_comb begin
    pcnt_d = pcnt_q;
    wrap_d = 1'b0;
    if (clr) begin
      pcnt_d = '0;
    end else if (inc) begin
      if (pcnt_q == PCNT_LAST) begin
        pcnt_d = '0;
        wrap_d = 1'b1;
      end else begin
        pcnt_d = pcnt_q + 7'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pcnt_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      pcnt_q <= pcnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign pcnt = pcnt_q;
  assign wrap = wrap_q;

endmodule

// File: rtl/pls_gen_div.sv
// 50% duty pulse generator with programmable half period and pulse tally.
//   clk  : system clock
//   rst  : synchronous active-low reset
//   en   : run request; dropping it lets the current pulse finish
//   clr  : synchronous abort/clear, priority over en
//   half : clocks per output level, sampled at each HIGH entry
//   plso : registered square wave
//   tick : one-clock strobe on each plso falling edge
//   pcnt : completed pulses modulo 100
//   wrap : one-clock strobe when pcnt rolls over
//   busy : generator is not idle
//
// state   | meaning
// --------+---------------------------------------------
// ST_IDLE | stopped, plso low, waiting for en
// ST_HIGH | plso high, timer counting down the level
// ST_LOW  | plso low, timer counting down the level
module pls_gen_div
  import pls_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int MIN_HALF = MIN_HALF_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] half,
  output logic             plso,
  output logic             tick,
  output logic [6:0]       pcnt,
  output logic             wrap,
  output logic             busy
);

  localparam logic [CNT_W-1:0] MIN_H = CNT_W'(MIN_HALF);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] h_q, h_d;
  logic             plso_q, plso_d;
  logic             tick_q, tick_d;
  logic             inc;
  logic [CNT_W-1:0] h_sel;

  // Short settings are stretched so no level can be shorter than MIN_HALF.
  assign h_sel = (half < MIN_H) ? MIN_H : half;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    h_d     = h_q;
    plso_d  = 1'b0;
    tick_d  = 1'b0;
    inc     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d = ST_HIGH;
          h_d     = h_sel;
          timer_d = h_sel - ONE;
          plso_d  = 1'b1;
        end
      end
      ST_HIGH: begin
        plso_d = 1'b1;
        if (timer_q == '0) begin
          state_d = ST_LOW;
          plso_d  = 1'b0;
          tick_d  = 1'b1;
          inc     = 1'b1;
          timer_d = h_q - ONE;
        end else begin
          timer_d = timer_q - ONE;
        end
      end
      ST_LOW: begin
        if (timer_q == '0) begin
          if (en) begin
            state_d = ST_HIGH;
            h_d     = h_sel;
            timer_d = h_sel - ONE;
            plso_d  = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          timer_d = timer_q - ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase

    // Abort may cut a HIGH level short; that pulse is not counted.
    if (clr) begin
      state_d = ST_IDLE;
      timer_d = '0;
      plso_d  = 1'b0;
      tick_d  = 1'b0;
      inc     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      h_q     <= MIN_H;
      plso_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      h_q     <= h_d;
      plso_q  <= plso_d;
      tick_q  <= tick_d;
    end
  end

  pls_tally_100 u_tally (
    .clk  (clk),
    .rst  (rst),
    .inc  (inc),
    .clr  (clr),
    .pcnt (pcnt),
    .wrap (wrap)
  );

  assign plso = plso_q;
  assign tick = tick_q;
  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pls_gen_div.sv
module tb_pls_gen_div;

  localparam int W    = 8;
  localparam int MINH = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en  = 1'b0;
  logic         clr = 1'b0;
  logic [W-1:0] half = '0;
  logic         plso, tick, wrap, busy;
  logic [6:0]   pcnt;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: a pulse is "active" from its start edge; pos counts
  // clocks since that start. Output is high for the first h clocks of the
  // 2h-clock pulse, and the tick lands on the clock where pos reaches h.
  bit m_active = 1'b0;
  int m_pos    = 0;
  int m_h      = MINH;
  int m_pcnt   = 0;
  bit m_tick   = 1'b0;
  bit m_wrap   = 1'b0;
  int wrap_seen = 0;

  always #5 clk = ~clk;

  pls_gen_div #(.CNT_W(W), .MIN_HALF(MINH)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (clr),
    .half (half),
    .plso (plso),
    .tick (tick),
    .pcnt (pcnt),
    .wrap (wrap),
    .busy (busy)
  );

  function automatic int clamp_h(input int v);
    return (v < MINH) ? MINH : v;
  endfunction

  task automatic model_step(input bit r, input bit e, input bit c, input int hv);
    m_tick = 1'b0;
    m_wrap = 1'b0;
    if (!r || c) begin
      m_active = 1'b0;
      m_pos    = 0;
      m_pcnt   = 0;
    end else if (!m_active) begin
      if (e) begin
        m_active = 1'b1;
        m_pos    = 0;
        m_h      = clamp_h(hv);
      end
    end else begin
      m_pos++;
      if (m_pos == m_h) begin
        m_tick = 1'b1;
        m_pcnt = (m_pcnt + 1) % 100;
        m_wrap = (m_pcnt == 0);
      end
      if (m_pos == 2 * m_h) begin
        if (e) begin
          m_pos = 0;
          m_h   = clamp_h(hv);
        end else begin
          m_active = 1'b0;
        end
      end
    end
  endtask

  task automatic check_all();
    bit   e_plso;
    e_plso = m_active && (m_pos < m_h);
    n_total++;
    assert (plso === e_plso) n_pass++;
    else $error("FAIL plso obs=%0b exp=%0b t=%0t", plso, e_plso, $time);
    n_total++;
    assert (tick === m_tick) n_pass++;
    else $error("FAIL tick obs=%0b exp=%0b t=%0t", tick, m_tick, $time);
    n_total++;
    assert (wrap === m_wrap) n_pass++;
    else $error("FAIL wrap obs=%0b exp=%0b t=%0t", wrap, m_wrap, $time);
    n_total++;
    assert (pcnt === 7'(m_pcnt)) n_pass++;
    else $error("FAIL pcnt obs=%0d exp=%0d t=%0t", pcnt, m_pcnt, $time);
    n_total++;
    assert (busy === m_active) n_pass++;
    else $error("FAIL busy obs=%0b exp=%0b t=%0t", busy, m_active, $time);
  endtask

  task automatic cyc(input bit r, input bit e, input bit c, input int hv);
    rst  = r;
    en   = e;
    clr  = c;
    half = W'(hv);
    @(posedge clk);
    model_step(r, e, c, hv);
    #1;
    if (wrap === 1'b1) wrap_seen++;
    check_all();
  endtask

  task automatic run(input int n, input bit e, input int hv);
    for (int i = 0; i < n; i++) cyc(1'b1, e, 1'b0, hv);
  endtask

  initial begin
    // reset has priority over en and clr
    cyc(1'b0, 1'b1, 1'b0, 3);
    cyc(1'b0, 1'b1, 1'b1, 3);
    cyc(1'b0, 1'b0, 1'b0, 3);

    // half=3 steady train, then half=0 and half=1 both clamp to 2
    run(30, 1'b1, 3);
    run(20, 1'b1, 0);
    run(20, 1'b1, 1);
    run(10, 1'b0, 1);

    // 100 pulses at half=5: exactly one wrap, on the 100th tick
    cyc(1'b1, 1'b0, 1'b1, 5);
    wrap_seen = 0;
    run(1000, 1'b1, 5);
    n_total++;
    assert (wrap_seen == 1) n_pass++;
    else $error("FAIL wrap_count obs=%0d exp=1", wrap_seen);
    run(12, 1'b0, 5);

    // en dropped one clock into HIGH; then half changed mid-HIGH
    cyc(1'b1, 1'b1, 1'b0, 4);
    run(12, 1'b0, 4);
    n_total++;
    assert (busy === 1'b0) n_pass++;
    else $error("FAIL idle_after_drop obs=%0b exp=0", busy);
    run(2, 1'b1, 4);
    run(24, 1'b1, 6);
    run(14, 1'b0, 6);

    // clr two clocks into HIGH with pcnt=37
    cyc(1'b1, 1'b0, 1'b1, 4);
    run(296, 1'b1, 4);
    n_total++;
    assert (pcnt === 7'd37) n_pass++;
    else $error("FAIL pcnt_before_clr obs=%0d exp=37", pcnt);
    run(2, 1'b1, 4);
    cyc(1'b1, 1'b1, 1'b1, 4);
    run(20, 1'b1, 4);

    // reset mid-LOW with pcnt=12, then resume
    cyc(1'b1, 1'b0, 1'b1, 3);
    run(71, 1'b1, 3);
    n_total++;
    assert (pcnt === 7'd12 && plso === 1'b0 && busy === 1'b1) n_pass++;
    else $error("FAIL pre_reset_state pcnt=%0d plso=%0b busy=%0b exp 12/0/1", pcnt, plso, busy);
    cyc(1'b0, 1'b1, 1'b0, 3);
    run(30, 1'b1, 3);

    // largest half setting
    run(520, 1'b1, (1 << W) - 1);
    run(520, 1'b0, 2);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit r, e, c;
      int hv;
      r  = ($urandom_range(0, 299) != 0);
      c  = ($urandom_range(0, 149) == 0);
      e  = ($urandom_range(0, 9) != 0);
      hv = ($urandom_range(0, 99) == 0) ? 40 : int'($urandom_range(0, 9));
      cyc(r, e, c, hv);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
